// File: rtl/servo_pkg.sv
// Shared command codes and motion-state encodings for the servo angle path.
// Used by the PWM driver here and by the upstream switch/angle FSMs.
// Pure declarations plus one combinational decode helper.
package servo_pkg;

  // 4-bit angle command codes exchanged between the angle FSMs and the driver
  localparam logic [3:0] CMD_HOLD = 4'd0;
  localparam logic [3:0] CMD_DEC  = 4'd1;
  localparam logic [3:0] CMD_INC  = 4'd2;
  localparam logic [3:0] CMD_REL  = 4'd5;

  // Motion state of one servo axis
  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_DEC  = 2'd1,
    S_INC  = 2'd2
  } servo_state_e;

  // Map a command code onto a motion state; unknown codes (and release) hold
  function automatic servo_state_e decode_cmd(input logic [3:0] cmd);
    servo_state_e st;
    case (cmd)
      CMD_DEC: st = S_DEC;
      CMD_INC: st = S_INC;
      default: st = S_HOLD;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// PWM frame timer: free-running 0..PERIOD_TICKS-1 counter with frame strobes.
// o_Frame_End is combinational on the last count; o_Frame_Start is registered
// (high the cycle after cnt==0). No backpressure; runs every clock.
module servo_frame_timer #(
  parameter  int unsigned PERIOD_TICKS = 500000,
  localparam int unsigned W            = $clog2(PERIOD_TICKS + 1)
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  output logic [W-1:0] o_Cnt,
  output logic         o_Frame_End,
  output logic         o_Frame_Start
);

  localparam logic [W-1:0] LAST_CNT = W'(PERIOD_TICKS - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         frame_start_q, frame_start_d;
  logic         frame_end;

  // Next count with wrap at the last tick of the frame; start strobe follows cnt==0
  always_comb begin
    frame_end     = (cnt_q == LAST_CNT);
    cnt_d         = frame_end ? '0 : cnt_q + W'(1);
    frame_start_d = (cnt_q == '0);
  end

  // Counter and start-strobe registers; reset parks the counter at the frame origin
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cnt_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_Cnt         = cnt_q;
  assign o_Frame_End   = frame_end;
  assign o_Frame_Start = frame_start_q;

endmodule

// File: rtl/servo_pwm_driver.sv
// Servo PWM driver: angle command -> motion state -> clamped pulse width -> PWM pin.
// Latency: command sampled on the last tick of a frame, new width on the next frame (<= 1 frame + 1 cycle).
// No backpressure: commands are level-sampled once per frame, mid-frame values are ignored.
module servo_pwm_driver
  import servo_pkg::*;
#(
  parameter  int unsigned PERIOD_TICKS = 500000,
  parameter  int unsigned MIN_TICKS    = 25000,
  parameter  int unsigned MAX_TICKS    = 50000,
  parameter  int unsigned CENTER_TICKS = 37500,
  parameter  int unsigned STEP_TICKS   = 250,
  localparam int unsigned W            = $clog2(PERIOD_TICKS + 1)
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic [3:0]   i_Angle_Cmd,
  output logic         o_Pwm,
  output logic [W-1:0] o_Pulse_Width,
  output logic         o_At_Min,
  output logic         o_At_Max,
  output logic         o_Moving,
  output logic         o_Frame_Start
);

  // Clamp/step constants carried one bit wider so add/subtract cannot wrap
  localparam logic [W:0]   MIN_X    = (W + 1)'(MIN_TICKS);
  localparam logic [W:0]   MAX_X    = (W + 1)'(MAX_TICKS);
  localparam logic [W:0]   STEP_X   = (W + 1)'(STEP_TICKS);
  localparam logic [W-1:0] MIN_W    = W'(MIN_TICKS);
  localparam logic [W-1:0] MAX_W    = W'(MAX_TICKS);
  localparam logic [W-1:0] CENTER_W = W'(CENTER_TICKS);

  logic [W-1:0] cnt;
  logic         frame_end;
  logic         frame_start;

  servo_state_e state_q, state_d;

  logic [W-1:0] width_q, width_d;
  logic [W:0]   inc_sum;
  logic [W:0]   dec_diff;
  logic         pwm_q, pwm_d;
  logic         at_min_q, at_min_d;
  logic         at_max_q, at_max_d;
  logic         moving_q, moving_d;

  servo_frame_timer #(
    .PERIOD_TICKS (PERIOD_TICKS)
  ) u_frame_timer (
    .i_Clk         (i_Clk),
    .i_Rst         (i_Rst),
    .o_Cnt         (cnt),
    .o_Frame_End   (frame_end),
    .o_Frame_Start (frame_start)
  );

  // Motion-state register; reset returns the axis to hold
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= S_HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: command decoded only on the last tick of the frame, otherwise stay
  always_comb begin
    state_d = state_q;
    if (frame_end) begin
      state_d = decode_cmd(i_Angle_Cmd);
    end
  end

  // Width step with saturation, flags from the updated width/state, PWM compare
  always_comb begin
    inc_sum  = {1'b0, width_q} + STEP_X;
    dec_diff = {1'b0, width_q} - STEP_X;
    width_d  = width_q;
    at_min_d = at_min_q;
    at_max_d = at_max_q;
    moving_d = moving_q;
    // Compare against the width in force for this frame; the frame-end update
    // lands on the same edge as the last (always low) PWM tick.
    pwm_d    = (cnt < width_q);
    if (frame_end) begin
      case (state_d)
        S_INC:   width_d = (inc_sum > MAX_X) ? MAX_W : inc_sum[W-1:0];
        // dec_diff[W] catches a borrow when the step exceeds the width itself
        S_DEC:   width_d = (dec_diff[W] || (dec_diff < MIN_X)) ? MIN_W : dec_diff[W-1:0];
        default: width_d = width_q;
      endcase
      at_min_d = (width_d == MIN_W);
      at_max_d = (width_d == MAX_W);
      moving_d = (state_d == S_DEC) || (state_d == S_INC);
    end
  end

  // Width, flag and PWM registers; reset recentres and silences the pin
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      width_q  <= CENTER_W;
      pwm_q    <= 1'b0;
      at_min_q <= 1'b0;
      at_max_q <= 1'b0;
      moving_q <= 1'b0;
    end else begin
      width_q  <= width_d;
      pwm_q    <= pwm_d;
      at_min_q <= at_min_d;
      at_max_q <= at_max_d;
      moving_q <= moving_d;
    end
  end

  assign o_Pwm         = pwm_q;
  assign o_Pulse_Width = width_q;
  assign o_At_Min      = at_min_q;
  assign o_At_Max      = at_max_q;
  assign o_Moving      = moving_q;
  assign o_Frame_Start = frame_start;

endmodule
